// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: extracts and extends load data, registers the four
// write-back operands, and tracks sticky halt plus a retired-instruction count.
module mem_wb_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_SEL  = 2,
  parameter int NB_LOAD = 3
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               valid_i,
  input  logic [NB_DATA-1:0] alu_result_i,
  input  logic [NB_DATA-1:0] mem_rdata_i,
  input  logic [NB_DATA-1:0] pc_link_i,
  input  logic [NB_DATA-1:0] imm_i,
  input  logic [NB_LOAD-1:0] load_type_i,
  input  logic [NB_SEL-1:0]  wb_sel_i,
  input  logic [NB_REG-1:0]  reg_dst_i,
  input  logic               reg_write_i,
  input  logic               halt_i,
  output logic [NB_DATA-1:0] alu_result_o,
  output logic [NB_DATA-1:0] mem_data_o,
  output logic [NB_DATA-1:0] pc_link_o,
  output logic [NB_DATA-1:0] imm_o,
  output logic [NB_SEL-1:0]  wb_sel_o,
  output logic [NB_REG-1:0]  reg_dst_o,
  output logic               reg_write_o,
  output logic               misaligned_o,
  output logic               halted_o,
  output logic [NB_DATA-1:0] retired_o
);

  localparam logic [NB_LOAD-1:0] LT_LH  = 3'd1;
  localparam logic [NB_LOAD-1:0] LT_LHU = 3'd2;
  localparam logic [NB_LOAD-1:0] LT_LB  = 3'd3;
  localparam logic [NB_LOAD-1:0] LT_LBU = 3'd4;
  localparam logic [NB_SEL-1:0]  SEL_MEM = 2'b01;

  // Little-endian lane pick with sign/zero extension; unknown codes behave as LW.
  function automatic logic [NB_DATA-1:0] extract_load(
    input logic [NB_LOAD-1:0] lt,
    input logic [1:0]         off,
    input logic [NB_DATA-1:0] word
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (lt)
      LT_LB:   extract_load = {{(NB_DATA-8){b[7]}}, b};
      LT_LBU:  extract_load = {{(NB_DATA-8){1'b0}}, b};
      LT_LH:   extract_load = {{(NB_DATA-16){h[15]}}, h};
      LT_LHU:  extract_load = {{(NB_DATA-16){1'b0}}, h};
      default: extract_load = word;
    endcase
  endfunction

  logic [1:0]         off_s;
  logic               is_half_s;
  logic               is_byte_s;
  logic               misaligned_s;
  logic [NB_DATA-1:0] load_data_s;
  logic               reg_write_s;

  logic [NB_DATA-1:0] alu_result_r;
  logic [NB_DATA-1:0] mem_data_r;
  logic [NB_DATA-1:0] pc_link_r;
  logic [NB_DATA-1:0] imm_r;
  logic [NB_SEL-1:0]  wb_sel_r;
  logic [NB_REG-1:0]  reg_dst_r;
  logic               reg_write_r;
  logic               misaligned_r;
  logic               halted_r;
  logic [NB_DATA-1:0] retired_r;

  // Load extraction, alignment check and $0 write suppression ahead of the register.
  always_comb begin
    off_s        = alu_result_i[1:0];
    is_half_s    = (load_type_i == LT_LH) || (load_type_i == LT_LHU);
    is_byte_s    = (load_type_i == LT_LB) || (load_type_i == LT_LBU);
    load_data_s  = extract_load(load_type_i, off_s, mem_rdata_i);
    misaligned_s = 1'b0;
    if (valid_i && (wb_sel_i == SEL_MEM)) begin
      if (is_half_s) begin
        misaligned_s = off_s[0];
      end else if (!is_byte_s) begin
        misaligned_s = (off_s != 2'b00);
      end else begin
        misaligned_s = 1'b0;
      end
    end else begin
      misaligned_s = 1'b0;
    end
    reg_write_s = reg_write_i && valid_i && (reg_dst_i != {NB_REG{1'b0}});
  end

  // Stage register: halt freezes everything, then enable, flush (bubble), stall, capture.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      alu_result_r <= {NB_DATA{1'b0}};
      mem_data_r   <= {NB_DATA{1'b0}};
      pc_link_r    <= {NB_DATA{1'b0}};
      imm_r        <= {NB_DATA{1'b0}};
      wb_sel_r     <= {NB_SEL{1'b0}};
      reg_dst_r    <= {NB_REG{1'b0}};
      reg_write_r  <= 1'b0;
      misaligned_r <= 1'b0;
      halted_r     <= 1'b0;
      retired_r    <= {NB_DATA{1'b0}};
    end else if (!halted_r && enable_i) begin
      if (flush_i) begin
        alu_result_r <= {NB_DATA{1'b0}};
        mem_data_r   <= {NB_DATA{1'b0}};
        pc_link_r    <= {NB_DATA{1'b0}};
        imm_r        <= {NB_DATA{1'b0}};
        wb_sel_r     <= {NB_SEL{1'b0}};
        reg_dst_r    <= {NB_REG{1'b0}};
        reg_write_r  <= 1'b0;
        misaligned_r <= 1'b0;
      end else if (!stall_i) begin
        alu_result_r <= alu_result_i;
        mem_data_r   <= load_data_s;
        pc_link_r    <= pc_link_i;
        imm_r        <= imm_i;
        wb_sel_r     <= wb_sel_i;
        reg_dst_r    <= reg_dst_i;
        reg_write_r  <= reg_write_s;
        misaligned_r <= misaligned_s;
        if (valid_i) begin
          retired_r <= retired_r + {{(NB_DATA-1){1'b0}}, 1'b1};
          if (halt_i) begin
            halted_r <= 1'b1;
          end
        end
      end
    end
  end

  assign alu_result_o = alu_result_r;
  assign mem_data_o   = mem_data_r;
  assign pc_link_o    = pc_link_r;
  assign imm_o        = imm_r;
  assign wb_sel_o     = wb_sel_r;
  assign reg_dst_o    = reg_dst_r;
  assign reg_write_o  = reg_write_r;
  assign misaligned_o = misaligned_r;
  assign halted_o     = halted_r;
  assign retired_o    = retired_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed vectors push hand-computed
// expected outputs; a negedge monitor pops and compares them one cycle later.
module tb_mem_wb_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] link;
    logic [31:0] imm;
    logic [1:0]  sel;
    logic [4:0]  dst;
    logic        rw;
    logic        mis;
    logic        halted;
    logic [31:0] ret;
  } out_t;

  typedef struct {
    out_t  exp;
    int    at;
    string name;
  } item_t;

  logic        clk;
  logic        rst_n;
  logic        enable, stall, flush, valid, reg_write, halt;
  logic [31:0] alu_result, mem_rdata, pc_link, imm;
  logic [2:0]  load_type;
  logic [1:0]  wb_sel;
  logic [4:0]  reg_dst;

  logic [31:0] alu_result_o, mem_data_o, pc_link_o, imm_o, retired_o;
  logic [1:0]  wb_sel_o;
  logic [4:0]  reg_dst_o;
  logic        reg_write_o, misaligned_o, halted_o;

  item_t q[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  out_t  last_e;

  mem_wb_stage dut (
    .clock_i(clk), .reset_i(rst_n), .enable_i(enable), .stall_i(stall),
    .flush_i(flush), .valid_i(valid), .alu_result_i(alu_result),
    .mem_rdata_i(mem_rdata), .pc_link_i(pc_link), .imm_i(imm),
    .load_type_i(load_type), .wb_sel_i(wb_sel), .reg_dst_i(reg_dst),
    .reg_write_i(reg_write), .halt_i(halt),
    .alu_result_o(alu_result_o), .mem_data_o(mem_data_o), .pc_link_o(pc_link_o),
    .imm_o(imm_o), .wb_sel_o(wb_sel_o), .reg_dst_o(reg_dst_o),
    .reg_write_o(reg_write_o), .misaligned_o(misaligned_o),
    .halted_o(halted_o), .retired_o(retired_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic out_t got();
    return {alu_result_o, mem_data_o, pc_link_o, imm_o, wb_sel_o, reg_dst_o,
            reg_write_o, misaligned_o, halted_o, retired_o};
  endfunction

  function automatic out_t mk(input logic [31:0] a, m, l, i, input logic [1:0] s,
                              input logic [4:0] d, input logic w, mi, h,
                              input logic [31:0] r);
    return {a, m, l, i, s, d, w, mi, h, r};
  endfunction

  // Monitor: compare each expectation on the negedge of the cycle it is due.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      item_t it;
      out_t  g;
      it = q.pop_front();
      g  = got();
      checks++;
      if (it.at != cyc || g !== it.exp) begin
        failures++;
        $display("FAIL %s: got=%h expected=%h (due cycle %0d, now %0d)",
                 it.name, g, it.exp, it.at, cyc);
      end
    end
  end

  task automatic apply(input string nm, input logic v, en, st, fl, hl,
                       input logic [31:0] a, rd, lk, im, input logic [2:0] lt,
                       input logic [1:0] sel, input logic [4:0] dst,
                       input logic rw, input out_t e);
    item_t it;
    @(posedge clk);
    #1;
    valid = v; enable = en; stall = st; flush = fl; halt = hl;
    alu_result = a; mem_rdata = rd; pc_link = lk; imm = im;
    load_type = lt; wb_sel = sel; reg_dst = dst; reg_write = rw;
    it.exp = e; it.at = cyc + 1; it.name = nm;
    q.push_back(it);
    last_e = e;
  endtask

  task automatic idle();
    valid = 1'b0; enable = 1'b0; stall = 1'b0; flush = 1'b0; halt = 1'b0;
    alu_result = 32'h0; mem_rdata = 32'h0; pc_link = 32'h0; imm = 32'h0;
    load_type = 3'd0; wb_sel = 2'd0; reg_dst = 5'd0; reg_write = 1'b0;
  endtask

  task automatic reset_check(input string nm);
    out_t zero;
    zero = '0;
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (got() !== zero) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", nm, got(), zero);
    end
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    checks++;
    if (got() !== out_t'('0)) begin
      failures++;
      $display("FAIL reset_init: got=%h expected=0", got());
    end
    #1 rst_n = 1'b1;

    //     name         v    en   st   fl   hl   alu           rdata         link      imm           lt    sel   dst   rw
    apply("lb",        1'b1,1'b1,1'b0,1'b0,1'b0,32'h0000_1003,32'h80FF_1234,32'h100,32'h1234_0000,3'd3,2'd1,5'd3,1'b1,
          mk(32'h1003,32'hFFFF_FF80,32'h100,32'h1234_0000,2'd1,5'd3,1'b1,1'b0,1'b0,32'd1));
    apply("lbu",       1'b1,1'b1,1'b0,1'b0,1'b0,32'h0000_1003,32'h80FF_1234,32'h100,32'h1234_0000,3'd4,2'd1,5'd3,1'b1,
          mk(32'h1003,32'h0000_0080,32'h100,32'h1234_0000,2'd1,5'd3,1'b1,1'b0,1'b0,32'd2));
    apply("lh_mis",    1'b1,1'b1,1'b0,1'b0,1'b0,32'h0000_2001,32'h8001_ABCD,32'h104,32'h0,3'd1,2'd1,5'd4,1'b1,
          mk(32'h2001,32'hFFFF_ABCD,32'h104,32'h0,2'd1,5'd4,1'b1,1'b1,1'b0,32'd3));
    apply("lhu_hi",    1'b1,1'b1,1'b0,1'b0,1'b0,32'h0000_2002,32'h8001_ABCD,32'h104,32'h0,3'd2,2'd1,5'd4,1'b1,
          mk(32'h2002,32'h0000_8001,32'h104,32'h0,2'd1,5'd4,1'b1,1'b0,1'b0,32'd4));
    apply("lw_mis",    1'b1,1'b1,1'b0,1'b0,1'b0,32'h0000_3002,32'hDEAD_BEEF,32'h108,32'hABCD_0000,3'd0,2'd1,5'd5,1'b1,
          mk(32'h3002,32'hDEAD_BEEF,32'h108,32'hABCD_0000,2'd1,5'd5,1'b1,1'b1,1'b0,32'd5));
    apply("lw_sel_alu",1'b1,1'b1,1'b0,1'b0,1'b0,32'h0000_3001,32'hDEAD_BEEF,32'h108,32'hABCD_0000,3'd0,2'd0,5'd5,1'b1,
          mk(32'h3001,32'hDEAD_BEEF,32'h108,32'hABCD_0000,2'd0,5'd5,1'b1,1'b0,1'b0,32'd6));
    apply("lb_off1",   1'b1,1'b1,1'b0,1'b0,1'b0,32'h0000_1001,32'h80FF_1234,32'h10C,32'h0,3'd3,2'd3,5'd6,1'b1,
          mk(32'h1001,32'h0000_0012,32'h10C,32'h0,2'd3,5'd6,1'b1,1'b0,1'b0,32'd7));
    apply("lh_hi_sx",  1'b1,1'b1,1'b0,1'b0,1'b0,32'h0000_2002,32'h8001_ABCD,32'h110,32'h0,3'd1,2'd1,5'd6,1'b1,
          mk(32'h2002,32'hFFFF_8001,32'h110,32'h0,2'd1,5'd6,1'b1,1'b0,1'b0,32'd8));
    apply("lt_other",  1'b1,1'b1,1'b0,1'b0,1'b0,32'h0000_2003,32'h1122_3344,32'h114,32'h0,3'd7,2'd1,5'd6,1'b1,
          mk(32'h2003,32'h1122_3344,32'h114,32'h0,2'd1,5'd6,1'b1,1'b1,1'b0,32'd9));
    apply("cap7",      1'b1,1'b1,1'b0,1'b0,1'b0,32'h0000_0077,32'hCAFE_F00D,32'h8,32'h0,3'd0,2'd0,5'd7,1'b1,
          mk(32'h77,32'hCAFE_F00D,32'h8,32'h0,2'd0,5'd7,1'b1,1'b0,1'b0,32'd10));
    for (int i = 0; i < 3; i++)
      apply("stall_hold",1'b1,1'b1,1'b1,1'b0,1'b0,32'h99,32'h1,32'h2,32'h3,3'd0,2'd1,5'd9,1'b1,last_e);
    apply("flush_stall",1'b1,1'b1,1'b1,1'b1,1'b0,32'h99,32'h1,32'h2,32'h3,3'd0,2'd1,5'd9,1'b1,
          mk(32'h0,32'h0,32'h0,32'h0,2'd0,5'd0,1'b0,1'b0,1'b0,32'd10));
    apply("dst0",      1'b1,1'b1,1'b0,1'b0,1'b0,32'h5,32'h6,32'h7,32'h8,3'd0,2'd0,5'd0,1'b1,
          mk(32'h5,32'h6,32'h7,32'h8,2'd0,5'd0,1'b0,1'b0,1'b0,32'd11));
    apply("enable0",   1'b1,1'b0,1'b0,1'b0,1'b0,32'hAA,32'hBB,32'hCC,32'hDD,3'd0,2'd1,5'd3,1'b1,last_e);
    apply("invalid",   1'b0,1'b1,1'b0,1'b0,1'b0,32'h9,32'hA,32'hB,32'hC,3'd0,2'd1,5'd5,1'b1,
          mk(32'h9,32'hA,32'hB,32'hC,2'd1,5'd5,1'b0,1'b0,1'b0,32'd11));
    @(posedge clk);
    reset_check("reset_mid");

    // Halt on the fifth valid instruction, then everything must stay frozen.
    for (int i = 1; i <= 4; i++)
      apply("pre_halt",1'b1,1'b1,1'b0,1'b0,1'b0,32'h10 + 32'(i),32'h0,32'h20,32'h0,3'd0,2'd0,5'(i),1'b1,
            mk(32'h10 + 32'(i),32'h0,32'h20,32'h0,2'd0,5'(i),1'b1,1'b0,1'b0,32'(i)));
    apply("halt",      1'b1,1'b1,1'b0,1'b0,1'b1,32'h55,32'h0,32'h58,32'h0,3'd0,2'd2,5'd5,1'b1,
          mk(32'h55,32'h0,32'h58,32'h0,2'd2,5'd5,1'b1,1'b0,1'b1,32'd5));
    apply("halted_cap",  1'b1,1'b1,1'b0,1'b0,1'b0,32'h66,32'h77,32'h88,32'h99,3'd0,2'd1,5'd6,1'b1,last_e);
    apply("halted_flush",1'b1,1'b1,1'b0,1'b1,1'b0,32'h66,32'h77,32'h88,32'h99,3'd0,2'd1,5'd6,1'b1,last_e);
    apply("halted_stall",1'b1,1'b1,1'b1,1'b0,1'b0,32'h67,32'h78,32'h89,32'h9A,3'd1,2'd3,5'd7,1'b1,last_e);
    @(posedge clk);
    reset_check("reset_halted");

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register of the 5-stage MIPS core.
- Captures memory-stage results and extracts/sign-extends load data from the raw data-memory word.
- Presents the four write-back candidates plus the selector to the write-back mux; forwards destination register and write enable to the register file and forwarding unit.
- Tracks pipeline halt and a retired-instruction counter for the debug unit.

Parameters:
- NB_DATA, 32, datapath width.
- NB_REG, 5, register-address width.
- NB_SEL, 2, write-back selector width.
- NB_LOAD, 3, load-type code width.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  debug-unit step/run enable; 0 freezes the stage.
- stall_i  in  1  hold current contents.
- flush_i  in  1  load a bubble.
- valid_i  in  1  incoming slot holds a real instruction.
- alu_result_i  in  NB_DATA  ALU result; bits [1:0] are the byte offset for loads.
- mem_rdata_i  in  NB_DATA  raw aligned word from data memory.
- pc_link_i  in  NB_DATA  return address, PC+8.
- imm_i  in  NB_DATA  LUI immediate, already shifted.
- load_type_i  in  NB_LOAD  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; others are treated as LW.
- wb_sel_i  in  NB_SEL  00 ALU, 01 MEM, 10 LINK, 11 IMM.
- reg_dst_i  in  NB_REG  destination register.
- reg_write_i  in  1  register-file write enable.
- halt_i  in  1  HALT instruction reached MEM.
- alu_result_o, mem_data_o, pc_link_o, imm_o  out  NB_DATA  write-back mux operands op1..op4.
- wb_sel_o  out  NB_SEL  write-back mux select.
- reg_dst_o  out  NB_REG.
- reg_write_o  out  1.
- misaligned_o  out  1  registered misalignment flag for the captured load.
- halted_o  out  1  sticky halt.
- retired_o  out  NB_DATA  retired-instruction count.

Behaviour:
- Reset (reset_i=0, asynchronous): every output is 0. Release takes effect at the next rising edge.
- Latency: exactly one cycle; inputs sampled at edge N appear on outputs after edge N.
- Edge priority: reset > halted_o=1 (hold everything) > enable_i=0 (hold) > flush_i (bubble) > stall_i (hold) > capture.
- Bubble contents: all data outputs 0, wb_sel_o=00, reg_dst_o=0, reg_write_o=0, misaligned_o=0. retired_o is unchanged.
- Capture: all data fields are registered. reg_write_o = reg_write_i & valid_i & (reg_dst_i != 0); writes to $0 are suppressed.
- Load extraction (combinational before the register), with off = alu_result_i[1:0] and little-endian byte lanes:
  - LB / LBU: byte mem_rdata_i[8*off+7 : 8*off], sign- or zero-extended respectively.
  - LH / LHU: halfword at off[1] (lane 0 = [15:0], lane 1 = [31:16]), sign- or zero-extended; off[0] is ignored.
  - LW: whole word; off is ignored.
- Misalignment: misaligned_o = 1 when valid_i & wb_sel_i==01 & ((LH/LHU & off[0]) | (LW & off!=0)). The data is still delivered using the rules above.
- Halt:
  - On capture with valid_i & halt_i, halted_o goes 1 at that edge and stays 1 until reset.
  - The halting instruction itself is captured and retired.
  - Later edges change nothing; stall_i and flush_i are ignored while halted.
- Retired counter: retired_o increments by 1 on every capture edge with valid_i=1. It wraps from 0xFFFFFFFF to 0. It does not increment on flush, stall, enable_i=0 or halted edges.
- Simultaneous flush_i and stall_i: flush wins.
- Reset mid-operation clears halted_o and retired_o immediately.

Test Plan:
- Reset while outputs are nonzero -> all outputs 0 within the same cycle, before any clock edge.
- LB, alu_result_i=0x1003, mem_rdata_i=0x80FF1234, valid, wb_sel 01 -> next edge mem_data_o=0xFFFFFF80, misaligned_o=0. Same stimulus with LBU -> 0x00000080.
- LH, alu_result_i=0x2001, mem_rdata_i=0x8001ABCD -> mem_data_o=0xFFFFABCD, misaligned_o=1. LHU with offset 2 -> 0x00008001.
- Capture reg_dst 7/reg_write 1, then stall 3 cycles, then flush together with stall -> outputs hold 3 cycles, then reg_write_o=0 and wb_sel_o=00; retired_o goes 1 -> 1 -> 1.
- reg_dst_i=0 with reg_write_i=1 -> reg_write_o=0; retired_o still increments.
- Halt on the 5th valid instruction, then keep driving valid inputs -> halted_o=1, retired_o=5 and outputs frozen; reset_i low -> halted_o=0, retired_o=0.
